// File: rtl/bfu_outq_reader.sv
// bfu_outq_reader: output queue between the BFU core and a host stream port.
// Words pushed by the core (O/OT) go through a one-word input stage, then a
// CAP-word circular buffer, then a registered M_DATA/M_VALID output stage.
// The input stage gives a two-cycle latency into an empty queue. It still
// passes one word per cycle when the core pushes and the host accepts on
// every cycle.
// LEVEL counts every word held anywhere in the path: the input stage, the
// buffer and the output register. A push is accepted only when LEVEL < CAP,
// so the buffer itself can never overrun.
// Optional feature: define BFU_OUTQ_DROPCNT_EN to build the 16-bit saturating
// drop counter on DROPS. Without it, DROPS is tied to zero.
module bfu_outq_reader #(
  parameter int BITSIZE = 8,
  parameter int QADDLEN = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [BITSIZE-1:0] O,
  input  logic               OT,
  output logic               OOVF,
  output logic [BITSIZE-1:0] M_DATA,
  output logic               M_VALID,
  input  logic               M_READY,
  output logic [QADDLEN:0]   LEVEL,
  output logic               OVF,
  input  logic               OVF_CLR,
  output logic [15:0]        DROPS
);

  localparam int CAP = 1 << QADDLEN;
  localparam logic [QADDLEN:0] CAP_LVL = (QADDLEN+1)'(CAP);
  localparam logic [QADDLEN:0] ONE     = (QADDLEN+1)'(1);

  // Buffer storage has no reset; the pointers alone define what is valid.
  logic [BITSIZE-1:0] mem_q [CAP];

  logic               stg_valid_q, stg_valid_d;
  logic [BITSIZE-1:0] stg_data_q,  stg_data_d;
  logic [QADDLEN:0]   wr_ptr_q,    wr_ptr_d;
  logic [QADDLEN:0]   rd_ptr_q,    rd_ptr_d;
  logic               m_valid_q,   m_valid_d;
  logic [BITSIZE-1:0] m_data_q,    m_data_d;
  logic [QADDLEN:0]   level_q,     level_d;
  logic               ovf_q,       ovf_d;

  logic               full;
  logic               push_acc;
  logic               drop;
  logic               xfer;
  logic [QADDLEN:0]   mem_cnt;
  logic               load;

  // Decode the handshakes from registered state only.
  always_comb begin
    full     = (level_q == CAP_LVL);
    push_acc = OT && !full;
    drop     = OT && full;
    xfer     = m_valid_q && M_READY;
    mem_cnt  = wr_ptr_q - rd_ptr_q;
    load     = (mem_cnt != '0) && (!m_valid_q || M_READY);
  end

  // Input stage: hold an accepted push for one cycle before the buffer write.
  always_comb begin
    stg_valid_d = push_acc;
    stg_data_d  = stg_data_q;
    if (push_acc) begin
      stg_data_d = O;
    end
  end

  // Pointer advance: write follows the input stage, read follows output loads.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (stg_valid_q) begin
      wr_ptr_d = wr_ptr_q + ONE;
    end
    if (load) begin
      rd_ptr_d = rd_ptr_q + ONE;
    end
  end

  // Output register: refill from the buffer whenever the slot is empty or being taken.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = mem_q[rd_ptr_q[QADDLEN-1:0]];
    end else if (xfer) begin
      m_valid_d = 1'b0;
    end
  end

  // Occupancy: +1 per accepted push, -1 per completed transfer.
  always_comb begin
    level_d = level_q;
    unique case ({push_acc, xfer})
      2'b10:   level_d = level_q + ONE;
      2'b01:   level_d = level_q - ONE;
      default: level_d = level_q;
    endcase
  end

  // Sticky overflow; a drop in the same cycle as a clear leaves it set.
  always_comb begin
    ovf_d = ovf_q;
    if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Buffer write port, fed from the input stage.
  always_ff @(posedge CLK) begin
    if (!RST && stg_valid_q) begin
      mem_q[wr_ptr_q[QADDLEN-1:0]] <= stg_data_q;
    end
  end

  // State registers with synchronous reset that discards everything in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stg_valid_q <= 1'b0;
      stg_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      level_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_data_q  <= stg_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      level_q     <= level_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef BFU_OUTQ_DROPCNT_EN
  logic [15:0] drops_q, drops_d;

  // Drop counter: saturates at 65535; a clear with a coincident drop restarts at 1.
  always_comb begin
    drops_d = drops_q;
    if (OVF_CLR) begin
      drops_d = drop ? 16'd1 : 16'd0;
    end else if (drop && (drops_q != 16'hFFFF)) begin
      drops_d = drops_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      drops_q <= '0;
    end else begin
      drops_q <= drops_d;
    end
  end

  assign DROPS = drops_q;
`else
  assign DROPS = 16'd0;
`endif

  assign OOVF    = full;
  assign M_DATA  = m_data_q;
  assign M_VALID = m_valid_q;
  assign LEVEL   = level_q;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_bfu_outq_reader.sv
// tb_bfu_outq_reader: self-checking bench for bfu_outq_reader (default parameters).
// A cycle table covers the basic latency and handshake behaviour. Hand-written
// sequences cover fill, overflow, clear and reset. A randomized stream is
// checked against a queue-based reference model.
module tb_bfu_outq_reader;

  localparam int BITSIZE = 8;
  localparam int QADDLEN = 10;
  localparam int CAP     = 1 << QADDLEN;

  logic               CLK;
  logic               RST;
  logic [BITSIZE-1:0] O;
  logic               OT;
  logic               OOVF;
  logic [BITSIZE-1:0] M_DATA;
  logic               M_VALID;
  logic               M_READY;
  logic [QADDLEN:0]   LEVEL;
  logic               OVF;
  logic               OVF_CLR;
  logic [15:0]        DROPS;

  int checks   = 0;
  int failures = 0;

  bfu_outq_reader #(.BITSIZE(BITSIZE), .QADDLEN(QADDLEN)) dut (
    .CLK(CLK), .RST(RST), .O(O), .OT(OT), .OOVF(OOVF),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .LEVEL(LEVEL), .OVF(OVF), .OVF_CLR(OVF_CLR), .DROPS(DROPS)
  );

  // 10 ns clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       ot;
    logic [7:0] o;
    logic       ready;
    logic       clr;
    int         expLevel;
    logic       expValid;
    logic [7:0] expData;
    logic       expOvf;
  } vec_t;

  vec_t vecs[10];

  // Expected drop count for a given number of drops, honouring the build option.
  function automatic int expDrops(input int n);
`ifdef BFU_OUTQ_DROPCNT_EN
    return n;
`else
    return 0;
`endif
  endfunction

  // Drive inputs, let one rising edge pass, then settle 1 ns after it.
  task automatic applyStimulus(input logic ot, input logic [7:0] o, input logic ready, input logic clr);
    OT      = ot;
    O       = o;
    M_READY = ready;
    OVF_CLR = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  task automatic doReset();
    RST = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    RST = 1'b0;
  endtask

  initial begin
    logic [7:0] mq[$];
    int mlevel;
    int mdrops;
    int pushed;
    int popped;
    int cyc;
    int n;
    logic       ot;
    logic       r;
    logic [7:0] o;
    logic       acc;
    logic       xf;
    logic       movf;

    RST = 1'b0; OT = 1'b0; O = '0; M_READY = 1'b0; OVF_CLR = 1'b0;

    // Cycle table: the row's inputs are applied before edge i; its expectations hold after edge i.
    vecs[0] = '{1'b1, 8'h41, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h41, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{1'b1, 8'hC3, 1'b0, 1'b0, 2, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b1, 8'h5A, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 2, 1'b1, 8'h5A, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b1, 8'hC3, 1'b0};
    vecs[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0};

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_level", int'(LEVEL), 0);
    checkOutput("rst_valid", int'(M_VALID), 0);
    checkOutput("rst_data", int'(M_DATA), 0);
    checkOutput("rst_ovf", int'(OVF), 0);
    checkOutput("rst_oovf", int'(OOVF), 0);
    checkOutput("rst_drops", int'(DROPS), 0);

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].ot, vecs[i].o, vecs[i].ready, vecs[i].clr);
      checkOutput($sformatf("vec%0d_level", i), int'(LEVEL), vecs[i].expLevel);
      checkOutput($sformatf("vec%0d_valid", i), int'(M_VALID), int'(vecs[i].expValid));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d_data", i), int'(M_DATA), int'(vecs[i].expData));
      end
      checkOutput($sformatf("vec%0d_ovf", i), int'(OVF), int'(vecs[i].expOvf));
    end

    $display("[TB] 256-word burst with host stalled, then drained");
    doReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("burst_level", int'(LEVEL), 256);
    checkOutput("burst_valid", int'(M_VALID), 1);
    checkOutput("burst_data", int'(M_DATA), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("burst_hold", int'(M_DATA), 0);
    for (int j = 0; j < 256; j++) begin
      checkOutput($sformatf("burst_v%0d", j), int'(M_VALID), 1);
      checkOutput($sformatf("burst_d%0d", j), int'(M_DATA), j);
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("burst_end_level", int'(LEVEL), 0);
    checkOutput("burst_end_valid", int'(M_VALID), 0);

    $display("[TB] fill to capacity and overflow");
    doReset();
    for (int i = 0; i < CAP; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0);
    end
    checkOutput("full_level", int'(LEVEL), CAP);
    checkOutput("full_oovf", int'(OOVF), 1);
    checkOutput("full_ovf", int'(OVF), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0);
    end
    checkOutput("drop3_level", int'(LEVEL), CAP);
    checkOutput("drop3_ovf", int'(OVF), 1);
    checkOutput("drop3_drops", int'(DROPS), expDrops(3));

    // Full queue with a push and a transfer together: the push is still dropped.
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("popdrop_level", int'(LEVEL), CAP - 1);
    checkOutput("popdrop_ovf", int'(OVF), 1);
    checkOutput("popdrop_oovf", int'(OOVF), 0);
    checkOutput("popdrop_drops", int'(DROPS), expDrops(4));

    // Refill, then clear coinciding with a drop: set wins.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("refill_level", int'(LEVEL), CAP);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b1);
    checkOutput("clrdrop_ovf", int'(OVF), 1);
    checkOutput("clrdrop_drops", int'(DROPS), expDrops(1));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_ovf", int'(OVF), 0);
    checkOutput("clr_drops", int'(DROPS), 0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    checkOutput("redrop_ovf", int'(OVF), 1);

    $display("[TB] drain to 500 and reset mid-operation");
    n = 0;
    while (LEVEL != 500 && n < 2000) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    checkOutput("drain_timeout", (n < 2000) ? 1 : 0, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("pre_rst_level", int'(LEVEL), 500);
    checkOutput("pre_rst_ovf", int'(OVF), 1);
    RST = 1'b1;
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    RST = 1'b0;
    OT = 1'b0; M_READY = 1'b0;
    checkOutput("mrst_level", int'(LEVEL), 0);
    checkOutput("mrst_valid", int'(M_VALID), 0);
    checkOutput("mrst_ovf", int'(OVF), 0);
    checkOutput("mrst_drops", int'(DROPS), 0);
    checkOutput("mrst_oovf", int'(OOVF), 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("post_rst_valid%0d", i), int'(M_VALID), 0);
      checkOutput($sformatf("post_rst_level%0d", i), int'(LEVEL), 0);
    end

    $display("[TB] random stream of 3000 words");
    doReset();
    mq.delete();
    mlevel = 0; mdrops = 0; movf = 1'b0; pushed = 0; popped = 0; cyc = 0;
    while ((pushed < 3000 || mq.size() > 0) && cyc < 20000) begin
      ot = (pushed < 3000) && ($urandom_range(3) != 0);
      o  = 8'($urandom);
      r  = (pushed >= 3000) ? 1'b1 : 1'($urandom_range(1));
      checkOutput("rnd_oovf", int'(OOVF), (mlevel == CAP) ? 1 : 0);
      xf = M_VALID && r;
      if (xf) begin
        if (mq.size() == 0) begin
          checkOutput("rnd_stray_word", 1, 0);
        end else begin
          checkOutput($sformatf("rnd_data%0d", popped), int'(M_DATA), int'(mq.pop_front()));
        end
        popped++;
      end
      acc = ot && (mlevel != CAP);
      if (acc) begin
        mq.push_back(o);
        pushed++;
      end else if (ot) begin
        movf = 1'b1;
        if (mdrops != 65535) mdrops++;
      end
      mlevel = mlevel + (acc ? 1 : 0) - (xf ? 1 : 0);
      applyStimulus(ot, o, r, 1'b0);
      checkOutput("rnd_level", int'(LEVEL), mlevel);
      checkOutput("rnd_ovf", int'(OVF), int'(movf));
      checkOutput("rnd_drops", int'(DROPS), expDrops(mdrops));
      cyc++;
    end
    checkOutput("rnd_timeout", (cyc < 20000) ? 1 : 0, 1);
    checkOutput("rnd_popped", popped, 3000);
    checkOutput("rnd_final_level", int'(LEVEL), 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("rnd_final_valid", int'(M_VALID), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
